// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift register command sequencer:
// register mode codes, command opcodes and controller state.
package shift_ctrl_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHR      = 2'b01;
    localparam logic [1:0] OP_SHL      = 2'b10;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPTURE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter for the shift phase; saturates at zero so a
// full-scale count never wraps, and flags the final cycle via last.
module shift_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a 4-mode universal shift register: accepts one
// command, drives mode/data_in for the needed cycles, returns data_out.
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state, state_next;
    logic [1:0]       op_q;
    logic [1:0]       op_sel;
    logic [1:0]       mode_next;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             accept, cnt_dec, capture, release_rsp;

    shift_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (cnt_dec),
        .load_val (cmd_cnt),
        .count    (count),
        .last     (last)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // The opcode is not latched yet on the accepting edge, so look at the bus then.
    assign op_sel = (state == ST_IDLE) ? cmd_op : op_q;

    always_comb begin
        state_next  = state;
        mode_next   = MODE_HOLD;
        accept      = 1'b0;
        cnt_dec     = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if ((cmd_op == OP_LOAD) || (cmd_op == OP_LOAD_SHR)) begin
                        state_next = ST_LOAD;
                    end else if (cmd_cnt != '0) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            ST_LOAD: begin
                if ((op_q == OP_LOAD_SHR) && (count != '0)) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                if (last) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                capture    = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // sr_mode is registered, so it is derived from the state being entered.
        case (state_next)
            ST_LOAD:  mode_next = MODE_LOAD;
            ST_SHIFT: mode_next = (op_sel == OP_SHL) ? MODE_SHL : MODE_SHR;
            default:  mode_next = MODE_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            sr_mode    <= MODE_HOLD;
            sr_data_in <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            op_q       <= OP_LOAD;
        end else begin
            state   <= state_next;
            sr_mode <= mode_next;
            if (accept) begin
                sr_data_in <= cmd_data;
                op_q       <= cmd_op;
            end
            if (capture) begin
                rsp_data  <= sr_data_out;
                rsp_valid <= 1'b1;
            end
            if (release_rsp) begin
                rsp_valid  <= 1'b0;
                sr_data_in <= '0;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl with a behavioural universal shift
// register attached and a queue of predicted responses.
module tb_shift_reg_ctrl;
    import shift_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic [1:0] sr_mode;
    logic [3:0] sr_data_in;
    logic [3:0] sr_data_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] shadow;
    logic [3:0] sr_q;

    always #5 clk = ~clk;

    shift_reg_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_cnt     (cmd_cnt),
        .sr_mode     (sr_mode),
        .sr_data_in  (sr_data_in),
        .sr_data_out (sr_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    // Universal shift register model, zero fill on both shift directions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= 4'b0000;
        end else begin
            case (sr_mode)
                MODE_SHR:  sr_q <= {1'b0, sr_q[3:1]};
                MODE_SHL:  sr_q <= {sr_q[2:0], 1'b0};
                MODE_LOAD: sr_q <= sr_data_in;
                default:   sr_q <= sr_q;
            endcase
        end
    end
    assign sr_data_out = sr_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] predict(input logic [3:0] cur, input logic [1:0] op,
                                           input logic [3:0] data, input logic [2:0] cnt);
        logic [3:0] r;
        r = cur;
        if ((op == OP_LOAD) || (op == OP_LOAD_SHR)) r = data;
        if (op != OP_LOAD) begin
            for (int i = 0; i < int'(cnt); i++) begin
                r = (op == OP_SHL) ? {r[2:0], 1'b0} : {1'b0, r[3:1]};
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_mode(input logic [1:0] op, input int i, input int n);
        if (i >= n) return MODE_HOLD;
        if (((op == OP_LOAD) || (op == OP_LOAD_SHR)) && (i == 0)) return MODE_LOAD;
        return (op == OP_SHL) ? MODE_SHL : MODE_SHR;
    endfunction

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " idle wait"}, 32'(ok), 32'(1));
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                           input logic [2:0] cnt, input int stall);
        int n;
        logic [3:0] exp_d;
        logic [3:0] got;
        n = (op == OP_LOAD) ? 1 : (op == OP_LOAD_SHR) ? 1 + int'(cnt) : int'(cnt);
        wait_idle(tag);
        rsp_ready = (stall == 0);
        cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_d = predict(shadow, op, data, cnt);
        exp_q.push_back(exp_d);
        shadow = exp_d;
        for (int i = 0; i <= n; i++) begin
            check({tag, " mode"}, 32'(sr_mode), 32'(exp_mode(op, i, n)));
            check({tag, " data_in"}, 32'(sr_data_in), 32'(data));
            check({tag, " early valid"}, 32'(rsp_valid), 32'(0));
            check({tag, " busy"}, 32'(busy), 32'(1));
            @(posedge clk); #1;
        end
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1));
        got = exp_q.pop_front();
        check({tag, " rsp_data"}, 32'(rsp_data), 32'(got));
        for (int s = 0; s < stall; s++) begin
            if (s == 1) begin
                cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = ~data;
            end
            check({tag, " stall valid"}, 32'(rsp_valid), 32'(1));
            check({tag, " stall data"}, 32'(rsp_data), 32'(got));
            check({tag, " stall ready"}, 32'(cmd_ready), 32'(0));
            check({tag, " stall mode"}, 32'(sr_mode), 32'(MODE_HOLD));
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " rsp drop"}, 32'(rsp_valid), 32'(0));
        check({tag, " ready back"}, 32'(cmd_ready), 32'(1));
        check({tag, " data_in clr"}, 32'(sr_data_in), 32'(0));
        check({tag, " no extra"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] b_op[4];
        logic [3:0] b_data[4];
        logic [2:0] b_cnt[4];
        logic ok;
        logic [3:0] e;

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0; cmd_cnt = 3'd0;
        rsp_ready = 1'b1; shadow = 4'h0;
        #12;
        check("reset mode", 32'(sr_mode), 32'(0));
        check("reset data_in", 32'(sr_data_in), 32'(0));
        check("reset rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset rsp_data", 32'(rsp_data), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset ready", 32'(cmd_ready), 32'(1));
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run_cmd("load", OP_LOAD, 4'b1010, 3'd0, 0);
        run_cmd("shr3", OP_SHR, 4'b0011, 3'd3, 0);
        run_cmd("shl0", OP_SHL, 4'b1111, 3'd0, 0);
        run_cmd("ldshr7", OP_LOAD_SHR, 4'b0111, 3'd7, 5);
        run_cmd("ldshr0", OP_LOAD_SHR, 4'b1001, 3'd0, 0);
        run_cmd("shl7", OP_SHL, 4'b0110, 3'd7, 0);
        run_cmd("load2", OP_LOAD, 4'b1100, 3'd5, 0);
        run_cmd("shr1", OP_SHR, 4'b0000, 3'd1, 0);
        run_cmd("ldshr2", OP_LOAD_SHR, 4'b1111, 3'd2, 1);

        // Reset during the second shift cycle of a five-cycle shift.
        wait_idle("abort");
        cmd_op = OP_SHR; cmd_data = 4'b1001; cmd_cnt = 3'd5; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("abort shift1", 32'(sr_mode), 32'(MODE_SHR));
        @(posedge clk); #1;
        check("abort shift2", 32'(sr_mode), 32'(MODE_SHR));
        #2 rst = 1'b0;
        #1;
        check("abort mode", 32'(sr_mode), 32'(0));
        check("abort valid", 32'(rsp_valid), 32'(0));
        check("abort busy", 32'(busy), 32'(0));
        check("abort data_in", 32'(sr_data_in), 32'(0));
        @(negedge clk); rst = 1'b1;
        shadow = 4'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort quiet valid", 32'(rsp_valid), 32'(0));
            check("abort quiet mode", 32'(sr_mode), 32'(0));
        end
        @(posedge clk); #1;
        run_cmd("post reset load", OP_LOAD, 4'b0101, 3'd0, 0);

        // Back-to-back commands with cmd_valid held high throughout.
        b_op[0] = OP_SHL;      b_data[0] = 4'b0000; b_cnt[0] = 3'd1;
        b_op[1] = OP_LOAD;     b_data[1] = 4'b1100; b_cnt[1] = 3'd0;
        b_op[2] = OP_SHR;      b_data[2] = 4'b0110; b_cnt[2] = 3'd2;
        b_op[3] = OP_LOAD_SHR; b_data[3] = 4'b1011; b_cnt[3] = 3'd1;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_op = b_op[k]; cmd_data = b_data[k]; cmd_cnt = b_cnt[k];
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (cmd_ready === 1'b1) begin
                    check("b2b idle mode", 32'(sr_mode), 32'(MODE_HOLD));
                    ok = 1'b1;
                    break;
                end
            end
            check("b2b accept", 32'(ok), 32'(1));
            @(posedge clk); #1;
            if (k == 3) cmd_valid = 1'b0;
            e = predict(shadow, b_op[k], b_data[k], b_cnt[k]);
            exp_q.push_back(e);
            shadow = e;
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) begin
                    check("b2b rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
                    ok = 1'b1;
                    break;
                end
                check("b2b busy ready", 32'(cmd_ready), 32'(0));
                check("b2b data_in", 32'(sr_data_in), 32'(b_data[k]));
            end
            check("b2b response", 32'(ok), 32'(1));
        end
        @(posedge clk); #1;
        check("b2b final idle", 32'(cmd_ready), 32'(1));
        check("b2b queue empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
